// File: rtl/serial_frame_tx.sv
// Moore serial frame transmitter: idle-high line, start 0, LSB-first data, optional even parity, stop bit(s) 1.
// Define SERIAL_FRAME_TX_PARITY_EN to insert one even-parity bit after the data bits.
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    generate
        if (DATA_W < 1 || BIT_CYCLES < 1 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
            $error("serial_frame_tx: illegal parameters DATA_W=%0d BIT_CYCLES=%0d STOP_BITS=%0d",
                   DATA_W, BIT_CYCLES, STOP_BITS);
        end
    endgenerate

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t              state_r, state_s;
    logic [CYC_W-1:0]    cyc_r, cyc_s;
    logic [BIT_W-1:0]    bit_r, bit_s;
    logic [DATA_W-1:0]   shift_r, shift_s;
    logic                tx_out_r, tx_out_s;
    logic                tx_ready_r;
    logic                busy_r;
    logic                done_r, done_s;
    logic                bit_end_s;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic                parity_r, parity_s;
`endif

    assign bit_end_s = (cyc_r == CYC_W'(BIT_CYCLES - 1));
    assign tx_ready  = tx_ready_r;
    assign tx_out    = tx_out_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state logic: frame sequencing, bit/cycle counting and the data shifter.
    always_comb begin
        state_s = state_r;
        cyc_s   = cyc_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        done_s  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (tx_valid && tx_ready_r) begin
                    state_s = S_START;
                    shift_s = tx_data;
                    cyc_s   = CYC_W'(0);
                    bit_s   = BIT_W'(0);
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_s = ^tx_data;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_s = S_DATA;
                    cyc_s   = CYC_W'(0);
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cyc_s = CYC_W'(0);
                    if (bit_r == BIT_W'(DATA_W - 1)) begin
                        bit_s = BIT_W'(0);
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_s   = bit_r + BIT_W'(1);
                        shift_s = shift_r >> 1;
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    state_s = S_STOP;
                    cyc_s   = CYC_W'(0);
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    cyc_s = CYC_W'(0);
                    if (bit_r == BIT_W'(STOP_BITS - 1)) begin
                        bit_s   = BIT_W'(0);
                        state_s = S_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        bit_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cyc_s   = CYC_W'(0);
                bit_s   = BIT_W'(0);
            end
        endcase
    end

    // Line level decoded from the upcoming state so the registered output lines up with it.
    always_comb begin
        tx_out_s = 1'b1;
        case (state_s)
            S_IDLE:   tx_out_s = 1'b1;
            S_START:  tx_out_s = 1'b0;
            S_DATA:   tx_out_s = shift_s[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: tx_out_s = parity_s;
`endif
            S_STOP:   tx_out_s = 1'b1;
            default:  tx_out_s = 1'b1;
        endcase
    end

    // State, counters and registered line outputs; reset aborts any frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cyc_r      <= CYC_W'(0);
            bit_r      <= BIT_W'(0);
            shift_r    <= DATA_W'(0);
            tx_out_r   <= 1'b1;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            cyc_r      <= cyc_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            tx_out_r   <= tx_out_s;
            tx_ready_r <= (state_s == S_IDLE);
            busy_r     <= (state_s != S_IDLE);
            done_r     <= done_s;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

endmodule
